// File: rtl/string_frame_tx.sv
// Serial frame transmitter for the string-detector link.
// Sends a latched frame MSB-first, then a quiet gap, and counts the overlapping
// occurrences of a pattern in the frame as a reference result for the detector.
module string_frame_tx #(
  parameter int unsigned FRAME_LEN = 20,
  parameter int unsigned GAP_LEN   = 4,
  parameter int unsigned PAT_W     = 4,
  parameter int unsigned CNT_W     = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [FRAME_LEN-1:0] in_frame,
  input  logic [PAT_W-1:0]     in_pattern,
  output logic                 serial_out,
  output logic                 serial_valid,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     match_count
);

  localparam int unsigned BitW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int unsigned GapW = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;

  typedef enum logic [1:0] {StIdle, StSend, StGap} state_t;

  state_t               state;
  logic [FRAME_LEN-1:0] shift;
  logic [PAT_W-1:0]     pattern;
  logic [PAT_W-1:0]     history;
  logic [CNT_W-1:0]     run_count;
  logic [BitW-1:0]      bit_cnt;
  logic [GapW-1:0]      gap_cnt;

  logic [FRAME_LEN-1:0] shift_next;
  logic [PAT_W-1:0]     hist_next;
  logic                 hit;
  logic [CNT_W-1:0]     run_next;
  logic                 last_bit;

  // Only in_ready is combinational, and it decodes state alone.
  assign in_ready = (state == StIdle);

  // Match bookkeeping for the bit currently on serial_out.
  always_comb begin
    shift_next = shift << 1;
    hist_next  = (history << 1) | PAT_W'(serial_out);
    hit        = (bit_cnt >= BitW'(PAT_W - 1)) && (hist_next == pattern);
    run_next   = run_count + CNT_W'(hit);
    last_bit   = (bit_cnt == BitW'(FRAME_LEN - 1));
  end

  // Transmit FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= StIdle;
      shift        <= '0;
      pattern      <= '0;
      history      <= '0;
      run_count    <= '0;
      bit_cnt      <= '0;
      gap_cnt      <= '0;
      serial_out   <= 1'b0;
      serial_valid <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      match_count  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        StIdle: begin
          if (in_valid) begin
            shift        <= in_frame;
            pattern      <= in_pattern;
            history      <= '0;
            run_count    <= '0;
            bit_cnt      <= '0;
            serial_out   <= in_frame[FRAME_LEN-1];
            serial_valid <= 1'b1;
            busy         <= 1'b1;
            state        <= StSend;
          end
        end
        StSend: begin
          history   <= hist_next;
          run_count <= run_next;
          shift     <= shift_next;
          if (last_bit) begin
            bit_cnt      <= '0;
            gap_cnt      <= '0;
            serial_out   <= 1'b0;
            serial_valid <= 1'b0;
            if (GAP_LEN == 0) begin
              state       <= StIdle;
              busy        <= 1'b0;
              done        <= 1'b1;
              match_count <= run_next;
            end else begin
              state <= StGap;
            end
          end else begin
            bit_cnt    <= bit_cnt + BitW'(1);
            serial_out <= shift_next[FRAME_LEN-1];
          end
        end
        StGap: begin
          if (gap_cnt == GapW'(GAP_LEN - 1)) begin
            state       <= StIdle;
            busy        <= 1'b0;
            done        <= 1'b1;
            match_count <= run_count;
          end else begin
            gap_cnt <= gap_cnt + GapW'(1);
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_string_frame_tx.sv
// Directed bench for string_frame_tx: frame serialisation, gap, done timing,
// reference match counts, back-to-back frames, mid-frame reset, ignored inputs.
module tb_string_frame_tx;

  localparam int unsigned FL = 20;
  localparam int unsigned GL = 4;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [19:0] in_frame;
  logic [3:0]  in_pattern;
  logic        serial_out;
  logic        serial_valid;
  logic        busy;
  logic        done;
  logic [4:0]  match_count;

  int checks = 0;
  int errors = 0;

  string_frame_tx #(
    .FRAME_LEN(20),
    .GAP_LEN  (4),
    .PAT_W    (4),
    .CNT_W    (5)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_frame    (in_frame),
    .in_pattern  (in_pattern),
    .serial_out  (serial_out),
    .serial_valid(serial_valid),
    .busy        (busy),
    .done        (done),
    .match_count (match_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Entered in cycle 1 after an accept edge; leaves in the done cycle (cycle FL+GL+1).
  task automatic check_frame(input logic [19:0] f, input logic [4:0] prev_cnt,
                             input logic [4:0] exp_cnt, input bit scramble);
    for (int c = 1; c <= FL + GL + 1; c++) begin
      if (c == 1) chk("count_held", 32'(match_count), 32'(prev_cnt));
      if (c <= FL) begin
        chk($sformatf("bit%0d", c - 1), 32'(serial_out), 32'(f[FL-c]));
        chk("valid_send", 32'(serial_valid), 32'd1);
        chk("busy_send", 32'(busy), 32'd1);
        chk("ready_send", 32'(in_ready), 32'd0);
        chk("done_send", 32'(done), 32'd0);
      end else if (c <= FL + GL) begin
        chk("out_gap", 32'(serial_out), 32'd0);
        chk("valid_gap", 32'(serial_valid), 32'd0);
        chk("busy_gap", 32'(busy), 32'd1);
        chk("ready_gap", 32'(in_ready), 32'd0);
        chk("done_gap", 32'(done), 32'd0);
      end else begin
        chk("done_pulse", 32'(done), 32'd1);
        chk("busy_done", 32'(busy), 32'd0);
        chk("ready_done", 32'(in_ready), 32'd1);
        chk("valid_done", 32'(serial_valid), 32'd0);
        chk("match_count", 32'(match_count), 32'(exp_cnt));
      end
      if (c < FL + GL + 1) begin
        if (scramble) begin
          if (c < FL + GL) begin
            in_frame   = 20'($urandom);
            in_pattern = 4'($urandom);
            in_valid   = 1'($urandom);
          end else begin
            in_valid = 1'b0;
          end
        end
        tick();
      end
    end
  endtask

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b1;
    in_frame   = 20'hFFFFF;
    in_pattern = 4'hF;
    tick();
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_out", 32'(serial_out), 32'd0);
    chk("rst_valid", 32'(serial_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_count", 32'(match_count), 32'd0);

    // T1: all ones, pattern 1111 -> 17 overlapping matches
    in_valid = 1'b1; in_frame = 20'hFFFFF; in_pattern = 4'hF;
    tick();
    in_valid = 1'b0;
    check_frame(20'hFFFFF, 5'd0, 5'd17, 1'b0);
    tick();
    chk("idle_after_t1", 32'(done), 32'd0);

    // T2: all zeros -> 0 matches
    in_valid = 1'b1; in_frame = 20'h00000; in_pattern = 4'hF;
    tick();
    in_valid = 1'b0;
    check_frame(20'h00000, 5'd17, 5'd0, 1'b0);
    tick();

    // T3: alternating, pattern 1010 -> 9 matches
    in_valid = 1'b1; in_frame = 20'hAAAAA; in_pattern = 4'b1010;
    tick();
    in_valid = 1'b0;
    check_frame(20'hAAAAA, 5'd0, 5'd9, 1'b0);
    tick();

    // T4: in_valid held high, second accept in the done cycle
    in_valid = 1'b1; in_frame = 20'hF0000; in_pattern = 4'hF;
    tick();
    in_frame = 20'h0000F;
    check_frame(20'hF0000, 5'd9, 5'd1, 1'b0);
    tick();
    in_valid = 1'b0;
    check_frame(20'h0000F, 5'd1, 5'd1, 1'b0);
    tick();

    // T5: reset in cycle 10 drops the frame
    in_valid = 1'b1; in_frame = 20'hFFFFF; in_pattern = 4'hF;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    chk("t5_valid_c10", 32'(serial_valid), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_ready", 32'(in_ready), 32'd1);
    chk("t5_valid", 32'(serial_valid), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_count", 32'(match_count), 32'd0);
    for (int i = 0; i < 16; i++) begin
      chk("t5_no_done", 32'(done), 32'd0);
      chk("t5_quiet", 32'(serial_valid), 32'd0);
      tick();
    end

    // T6: inputs disturbed during SEND/GAP; 0001 occurs 3 times in 12345
    in_valid = 1'b1; in_frame = 20'h12345; in_pattern = 4'b0001;
    tick();
    in_valid = 1'b0;
    check_frame(20'h12345, 5'd0, 5'd3, 1'b1);
    tick();
    chk("t6_done_one_cycle", 32'(done), 32'd0);
    chk("t6_idle", 32'(in_ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
